// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the shared-ALU arbiter.
// slave = arbiter, master = requesting clients, alu = the ALU instance.
interface alu_req_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = 2
);
   logic [N-1:0]    req;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N*4-1:0]  req_op;
   logic [N-1:0]    gnt;
   logic            resp_valid;
   logic [IDW-1:0]  resp_id;
   logic [31:0]     resp_result;
   logic            resp_err;
   logic            busy;
   logic [31:0]     alu_a;
   logic [31:0]     alu_b;
   logic [3:0]      alu_op;
   logic [31:0]     alu_result;

   modport slave (
      input  req, req_a, req_b, req_op, alu_result,
      output gnt, resp_valid, resp_id, resp_result, resp_err, busy,
             alu_a, alu_b, alu_op
   );

   modport master (
      output req, req_a, req_b, req_op,
      input  gnt, resp_valid, resp_id, resp_result, resp_err, busy
   );

   modport alu (
      input  alu_a, alu_b, alu_op,
      output alu_result
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between N requesters.
// One operation in flight; every output is a register.
module alu_req_arbiter #(
   parameter int N       = 4,
   parameter int ALU_LAT = 2,
   parameter int IDW     = 2
) (
   input  logic            clk,
   input  logic            reset,
   alu_req_arbiter_if.slave bus
);
   localparam logic [3:0]   OP_IDLE = 4'hF;
   localparam int           CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [N-1:0] ONE     = 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state_reg;
   logic [IDW-1:0] rr_reg;
   logic [IDW-1:0] win_reg;
   logic [3:0]     op_reg;
   logic [CW-1:0]  cnt_reg;

   logic           any_req;
   logic [IDW-1:0] win_next;
   logic [IDW-1:0] rr_next;

   logic [31:0] a_arr  [N];
   logic [31:0] b_arr  [N];
   logic [3:0]  op_arr [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign a_arr[gi]  = bus.req_a[32*gi +: 32];
         assign b_arr[gi]  = bus.req_b[32*gi +: 32];
         assign op_arr[gi] = bus.req_op[4*gi +: 4];
      end
   endgenerate

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0010, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1010: op_legal = 1'b1;
         default:                   op_legal = 1'b0;
      endcase
   endfunction

   // Priority search starting at rr_reg, wrapping modulo N.
   always_comb begin
      int idx;
      idx      = 0;
      any_req  = 1'b0;
      win_next = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_reg) + k;
         if (idx >= N) idx = idx - N;
         if (!any_req && bus.req[idx]) begin
            any_req  = 1'b1;
            win_next = IDW'(idx);
         end
      end
   end

   assign rr_next = (win_next == IDW'(N-1)) ? '0 : win_next + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         rr_reg          <= '0;
         win_reg         <= '0;
         op_reg          <= OP_IDLE;
         cnt_reg         <= '0;
         bus.gnt         <= '0;
         bus.resp_valid  <= 1'b0;
         bus.resp_id     <= '0;
         bus.resp_result <= '0;
         bus.resp_err    <= 1'b0;
         bus.busy        <= 1'b0;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_op      <= OP_IDLE;
      end else begin
         bus.gnt        <= '0;
         bus.resp_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  win_reg    <= win_next;
                  rr_reg     <= rr_next;
                  op_reg     <= op_arr[win_next];
                  bus.alu_a  <= a_arr[win_next];
                  bus.alu_b  <= b_arr[win_next];
                  // An illegal opcode never reaches the ALU.
                  bus.alu_op <= op_legal(op_arr[win_next]) ? op_arr[win_next] : OP_IDLE;
                  bus.gnt    <= ONE << win_next;
                  bus.busy   <= 1'b1;
                  state_reg  <= ISSUE;
               end
            end
            ISSUE: begin
               if (!op_legal(op_reg)) begin
                  bus.resp_valid  <= 1'b1;
                  bus.resp_id     <= win_reg;
                  bus.resp_result <= '0;
                  bus.resp_err    <= 1'b1;
                  state_reg       <= RESP;
               end else begin
                  cnt_reg   <= CW'(ALU_LAT - 1);
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_reg == '0) begin
                  bus.resp_valid  <= 1'b1;
                  bus.resp_id     <= win_reg;
                  bus.resp_result <= bus.alu_result;
                  bus.resp_err    <= 1'b0;
                  bus.alu_op      <= OP_IDLE;
                  state_reg       <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            RESP: begin
               bus.busy  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin/ALU model.
module tb_alu_req_arbiter;
   localparam int N       = 4;
   localparam int ALU_LAT = 2;
   localparam int IDW     = 2;

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0010, OP_AND = 4'b0100,
                          OP_OR  = 4'b0101, OP_XOR = 4'b0110, OP_NOR = 4'b0111,
                          OP_SLT = 4'b1010;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_req_arbiter_if #(.N(N), .IDW(IDW)) bus ();

   alu_req_arbiter #(.N(N), .ALU_LAT(ALU_LAT), .IDW(IDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int rr_model = 0;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      case (op)
         OP_ADD:  alu_fn = a + b;
         OP_SUB:  alu_fn = a - b;
         OP_AND:  alu_fn = a & b;
         OP_OR:   alu_fn = a | b;
         OP_XOR:  alu_fn = a ^ b;
         OP_NOR:  alu_fn = ~(a | b);
         OP_SLT:  alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: alu_fn = 32'd0;
      endcase
   endfunction

   function automatic bit legal(input logic [3:0] op);
      legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
              (op == OP_XOR) || (op == OP_NOR) || (op == OP_SLT);
   endfunction

   // First asserted requester at or after rr, wrapping.
   function automatic int model_winner(input logic [N-1:0] mask, input int rr);
      model_winner = -1;
      for (int k = N - 1; k >= 0; k--)
         if (mask[(rr + k) % N]) model_winner = (rr + k) % N;
   endfunction

   // ALU model with ALU_LAT registered stages.
   logic [31:0] pipe [ALU_LAT];
   always @(posedge clk) begin
      pipe[0] <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.alu_result = pipe[ALU_LAT-1];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_reqs();
      bus.req    = '0;
      bus.req_a  = '0;
      bus.req_b  = '0;
      bus.req_op = '0;
   endtask

   task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
      bus.req[i]            = 1'b1;
      bus.req_a[i*32 +: 32] = a;
      bus.req_b[i*32 +: 32] = b;
      bus.req_op[i*4 +: 4]  = op;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset    = 1'b0;
      rr_model = 0;
   endtask

   // Steps until a grant appears; dt = -1 if none within the bound.
   task automatic wait_gnt(output int dt, output logic [N-1:0] g);
      bit done;
      done = 0;
      dt   = -1;
      g    = '0;
      for (int k = 1; k <= 40 && !done; k++) begin
         step();
         if (bus.gnt !== '0) begin
            dt   = k;
            g    = bus.gnt;
            done = 1;
         end
      end
   endtask

   task automatic wait_resp(output int dt, output logic [IDW-1:0] id,
                            output logic [31:0] res, output logic err);
      bit done;
      done = 0;
      dt   = -1;
      id   = '0;
      res  = '0;
      err  = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         step();
         if (bus.resp_valid === 1'b1) begin
            dt   = k;
            id   = bus.resp_id;
            res  = bus.resp_result;
            err  = bus.resp_err;
            done = 1;
         end
      end
   endtask

   task automatic test_reset();
      clear_reqs();
      reset = 1'b1;
      step();
      step();
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
      n_cmp++; if (bus.resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id: got %0d want 0", bus.resp_id); end
      n_cmp++; if (bus.resp_result !== 32'd0) begin n_bad++; $display("FAIL reset_resp_result: got %h want 0", bus.resp_result); end
      n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin n_bad++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
      n_cmp++; if (bus.alu_op !== 4'hF) begin n_bad++; $display("FAIL reset_alu_op: got %h want f", bus.alu_op); end
      reset    = 1'b0;
      rr_model = 0;
      step();
      step();
      n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_quiet: busy %b gnt %b want 0 0000", bus.busy, bus.gnt); end
   endtask

   task automatic test_single();
      int dt; logic [N-1:0] g; logic [IDW-1:0] id; logic [31:0] res; logic err;
      drive(2, 32'd5, 32'd7, OP_ADD);
      wait_gnt(dt, g);
      clear_reqs();
      n_cmp++; if (dt !== 1) begin n_bad++; $display("FAIL single_gnt_cycle: got %0d want 1", dt); end
      n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", g); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      rr_model = 3;
      wait_resp(dt, id, res, err);
      $display("txn single id=%0d res=%h err=%b dt=%0d", id, res, err, dt);
      n_cmp++; if (dt !== ALU_LAT + 1) begin n_bad++; $display("FAIL single_resp_cycle: got %0d want %0d", dt, ALU_LAT + 1); end
      n_cmp++; if (id !== 2'd2 || res !== 32'd12 || err !== 1'b0) begin n_bad++; $display("FAIL single_resp: got id %0d res %0d err %b want 2 12 0", id, res, err); end
      step();
      n_cmp++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_result !== 32'd12) begin n_bad++; $display("FAIL single_after: valid %b busy %b res %0d want 0 0 12", bus.resp_valid, bus.busy, bus.resp_result); end
   endtask

   task automatic test_round_robin();
      int dt, last, w; logic [N-1:0] g, eg; logic [IDW-1:0] id; logic [31:0] res; logic err;
      do_reset();
      for (int i = 0; i < N; i++) drive(i, 32'd100 + 32'(i), 32'(i), OP_ADD);
      last = -1;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(dt, g);
         w  = model_winner(bus.req, rr_model);
         eg = '0;
         eg[w] = 1'b1;
         $display("txn rr grant=%b cycle=%0d", g, cyc);
         n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", n, g, eg); end
         if (last < 0) begin
            n_cmp++; if (dt !== 1) begin n_bad++; $display("FAIL rr_first_cycle: got %0d want 1", dt); end
         end else begin
            n_cmp++; if (cyc - last !== ALU_LAT + 3) begin n_bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", n, cyc - last, ALU_LAT + 3); end
         end
         last     = cyc;
         rr_model = (w + 1) % N;
      end
      clear_reqs();
      wait_resp(dt, id, res, err);
      n_cmp++; if (id !== 2'd0 || res !== 32'd100) begin n_bad++; $display("FAIL rr_last_resp: got id %0d res %0d want 0 100", id, res); end
      step();
   endtask

   task automatic test_illegal();
      int tg, tr; logic [N-1:0] g; logic [IDW-1:0] id; logic [31:0] res; logic err;
      tg = -1; tr = -1; g = '0; id = '0; res = '0; err = 1'b0;
      drive(1, 32'h1234, 32'h5678, 4'b0011);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (bus.gnt !== '0 && tg < 0) begin tg = k; g = bus.gnt; clear_reqs(); end
         if (bus.resp_valid === 1'b1 && tr < 0) begin
            tr = k; id = bus.resp_id; res = bus.resp_result; err = bus.resp_err;
         end
         n_cmp++; if (bus.alu_op !== 4'hF) begin n_bad++; $display("FAIL illegal_alu_op%0d: got %h want f", k, bus.alu_op); end
      end
      $display("txn illegal id=%0d res=%h err=%b", id, res, err);
      n_cmp++; if (tg !== 1 || g !== 4'b0010) begin n_bad++; $display("FAIL illegal_gnt: got %b at %0d want 0010 at 1", g, tg); end
      n_cmp++; if (tr !== 2) begin n_bad++; $display("FAIL illegal_resp_cycle: got %0d want 2", tr); end
      n_cmp++; if (id !== 2'd1 || res !== 32'd0 || err !== 1'b1) begin n_bad++; $display("FAIL illegal_resp: got id %0d res %h err %b want 1 0 1", id, res, err); end
      rr_model = 2;
   endtask

   task automatic test_contention();
      int dt; logic [N-1:0] g; logic [IDW-1:0] id; logic [31:0] res; logic err;
      drive(0, 32'd40, 32'd2, OP_SUB);
      wait_gnt(dt, g);
      clear_reqs();
      n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL cont_gnt0: got %b want 0001", g); end
      rr_model = 1;
      step();
      drive(3, 32'hAAAA_0000, 32'h00FF_00FF, OP_XOR);
      wait_gnt(dt, g);
      n_cmp++; if (dt !== ALU_LAT + 2) begin n_bad++; $display("FAIL cont_wait: gnt after %0d want %0d", dt, ALU_LAT + 2); end
      n_cmp++; if (g !== 4'b1000) begin n_bad++; $display("FAIL cont_gnt3: got %b want 1000", g); end
      clear_reqs();
      rr_model = 0;
      wait_resp(dt, id, res, err);
      $display("txn contention id=%0d res=%h err=%b", id, res, err);
      n_cmp++; if (id !== 2'd3 || res !== 32'hAA55_00FF) begin n_bad++; $display("FAIL cont_resp: got id %0d res %h want 3 aa5500ff", id, res); end
      step();
   endtask

   task automatic test_reset_mid();
      int dt; logic [N-1:0] g; logic [IDW-1:0] id; logic [31:0] res; logic err;
      drive(1, 32'd9, 32'd4, OP_SUB);
      wait_gnt(dt, g);
      step();
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async_ctl: busy %b gnt %b valid %b want 0", bus.busy, bus.gnt, bus.resp_valid); end
      n_cmp++; if (bus.alu_op !== 4'hF || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin n_bad++; $display("FAIL rmid_async_alu: op %h a %h b %h want f 0 0", bus.alu_op, bus.alu_a, bus.alu_b); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resp%0d: got %b want 0", k, bus.resp_valid); end
      end
      reset    = 1'b0;
      rr_model = 0;
      wait_gnt(dt, g);
      clear_reqs();
      n_cmp++; if (dt !== 1 || g !== 4'b0010) begin n_bad++; $display("FAIL rmid_regrant: got %b at %0d want 0010 at 1", g, dt); end
      rr_model = 2;
      wait_resp(dt, id, res, err);
      $display("txn reset_mid id=%0d res=%h err=%b", id, res, err);
      n_cmp++; if (dt !== ALU_LAT + 1 || id !== 2'd1 || res !== 32'd5 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_resp: got dt %0d id %0d res %0d err %b want %0d 1 5 0", dt, id, res, err, ALU_LAT + 1); end
      step();
   endtask

   task automatic test_opcode_sweep();
      logic [3:0] ops [6];
      logic [31:0] a, b;
      int dt, i; logic [N-1:0] g, eg;
      ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
      ops[3] = OP_NOR; ops[4] = OP_SUB; ops[5] = OP_SLT;
      a = 32'hF0F0_0000;
      b = 32'h0FF0_FFFF;
      for (int n = 0; n < 6; n++) begin
         i = int'($urandom_range(0, N - 1));
         drive(i, a, b, ops[n]);
         wait_gnt(dt, g);
         clear_reqs();
         eg = '0;
         eg[i] = 1'b1;
         n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL sweep_gnt%0d: got %b want %b", n, g, eg); end
         for (int k = 0; k <= ALU_LAT; k++) begin
            if (k > 0) step();
            n_cmp++;
            if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_op !== ops[n]) begin
               n_bad++;
               $display("FAIL sweep_stable%0d_%0d: got %h %h %h want %h %h %h", n, k, bus.alu_a, bus.alu_b, bus.alu_op, a, b, ops[n]);
            end
         end
         step();
         $display("txn sweep op=%h id=%0d res=%h", ops[n], bus.resp_id, bus.resp_result);
         n_cmp++;
         if (bus.resp_valid !== 1'b1 || bus.resp_result !== alu_fn(a, b, ops[n]) || bus.resp_id !== IDW'(i)) begin
            n_bad++;
            $display("FAIL sweep_resp%0d: valid %b res %h id %0d want 1 %h %0d", n, bus.resp_valid, bus.resp_result, bus.resp_id, alu_fn(a, b, ops[n]), i);
         end
         rr_model = (i + 1) % N;
         step();
      end
   endtask

   task automatic test_random();
      logic [3:0] legal_ops [7];
      logic [31:0] ra [N];
      logic [31:0] rb [N];
      logic [3:0]  rop [N];
      logic [N-1:0] mask, g, eg;
      logic [IDW-1:0] id; logic [31:0] res, eres; logic err;
      int dt, w, elat;
      legal_ops[0] = OP_ADD; legal_ops[1] = OP_SUB; legal_ops[2] = OP_AND; legal_ops[3] = OP_OR;
      legal_ops[4] = OP_XOR; legal_ops[5] = OP_NOR; legal_ops[6] = OP_SLT;
      for (int n = 0; n < 30; n++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            ra[i]  = $urandom;
            rb[i]  = $urandom;
            rop[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
            if (mask[i]) drive(i, ra[i], rb[i], rop[i]);
         end
         w  = model_winner(mask, rr_model);
         eg = '0;
         eg[w] = 1'b1;
         wait_gnt(dt, g);
         clear_reqs();
         n_cmp++; if (dt !== 1 || g !== eg) begin n_bad++; $display("FAIL rand_gnt%0d: got %b at %0d want %b at 1", n, g, dt, eg); end
         elat = legal(rop[w]) ? ALU_LAT + 1 : 1;
         eres = legal(rop[w]) ? alu_fn(ra[w], rb[w], rop[w]) : 32'd0;
         wait_resp(dt, id, res, err);
         $display("txn rand%0d mask=%b id=%0d op=%h res=%h err=%b", n, mask, id, rop[w], res, err);
         n_cmp++;
         if (dt !== elat || id !== IDW'(w) || res !== eres || err !== !legal(rop[w])) begin
            n_bad++;
            $display("FAIL rand_resp%0d: dt %0d id %0d res %h err %b want %0d %0d %h %b", n, dt, id, res, err, elat, w, eres, !legal(rop[w]));
         end
         rr_model = (w + 1) % N;
         step();
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_reqs();
      test_reset();
      test_single();
      test_round_robin();
      test_illegal();
      test_contention();
      test_reset_mid();
      test_opcode_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
